sram_port_ctl: RTL
==================

# sram_port_ctl

Request-side sequencer for the 64-entry toy SRAM. Accepts one read or write request at a time over a valid/ready handshake, registers address and control, and drives the glitch-free `strobe`, `enable` and `address[0:5]` inputs of the downstream address predecoder. It captures array read data and returns a response over a second valid/ready handshake. The block sits between the core-facing request interface and the predecode/array slice.

## Interface
- `DATA_WIDTH`, 32: width of write and read data.
- `STROBE_CYCLES`, 1: cycles strobe is held high. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in [0:5]: word address.
- `req_wdata` in [0:DATA_WIDTH-1]: write data.
- `strobe` out 1: registered array clock strobe to the predecoder.
- `enable` out 1: access enable to the predecoder.
- `wr_enable` out 1: write select to the array (1 = write cycle).
- `address` out [0:5]: registered address to the predecoder.
- `wr_data` out [0:DATA_WIDTH-1]: registered write data to the array.
- `rd_data` in [0:DATA_WIDTH-1]: array read data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out [0:DATA_WIDTH-1]: read data. Zero for write responses.
- `rsp_we` out 1: echoes `req_we` of the completed request.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready`=1. On `req_valid`, latch `req_we`, `req_addr`, `req_wdata` and go to SETUP.
  - SETUP: `enable`=1, `address` and `wr_enable` stable, `strobe`=0. Always go to STROBE next.
  - STROBE: `strobe`=1 and `enable`=1 for `STROBE_CYCLES` cycles, counted by a 4-bit down-counter.
    - On the edge ending the last STROBE cycle, a read captures `rd_data` into `rsp_rdata`.
    - Then go to RESP.
  - RESP: `rsp_valid`=1 and `enable`=0. On `rsp_ready`, go to IDLE.
- `req_ready` is high only in IDLE. There is no request pipelining, so at most one request is outstanding.
- `address`, `wr_data` and `wr_enable` hold their latched values from SETUP until the next accept.
- `strobe` comes straight from a flop: no combinational path from any input to `strobe`.
- `rsp_rdata`, `rsp_we` and `rsp_valid` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset values: state=IDLE, `req_ready`=1, `strobe`=0, `enable`=0, `wr_enable`=0, `address`=0, `wr_data`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_we`=0, counter=0.
- Reset mid-access: outputs take reset values asynchronously, so `strobe` drops immediately. The in-flight request is discarded with no response.

## Timing
- Accept at cycle 0 (handshake edge). SETUP is cycle 1. STROBE runs cycles 2..1+S. `rsp_valid` rises at cycle 2+S.
- With S=1 and `rsp_ready`=1:
  - `rsp_valid` occupies cycle 3.
  - `req_ready` is high again at cycle 4.
  - Peak throughput is one access per 4 cycles.
- `rd_data` must be valid at the rising edge that ends the last STROBE cycle.
- Response backpressure extends RESP indefinitely. `req_ready` stays low throughout.

## Configuration
- Macro `SRAM_PORT_BYPASS_EN`.
- When defined, the block keeps a last-write register (address, data, valid bit). The valid bit resets to 0 and is set by every completed write.
- A read whose address hits a valid entry goes IDLE→RESP directly:
  - `rsp_valid` at cycle 1, carrying the stored data.
  - `strobe` and `enable` are never asserted for that read.
- When not defined, the bypass logic is absent and every read takes the full array path.

## Structure
- Shared package `sram_pkg` holds:
  - `SRAM_ADDR_W`=6;
  - the FSM state enum `port_state_t` {IDLE, SETUP, STROBE, RESP};
  - the `STROBE_CYCLES` legal-range constants.
- No sub-module. The FSM, counter and bypass register sit in one module.
- Instantiated alongside `predecode`, driving its `strobe`, `enable` and `address` inputs.

## Test plan
- Reset then idle: hold `reset_n`=0 for 3 cycles, release → all outputs at reset values, `req_ready`=1, `strobe` never pulses.
- Write then read: write addr 0x2A, data 0xDEADBEEF, then read 0x2A with a model array. Expected:
  - `strobe` high exactly in cycle 2 of each access;
  - read `rsp_rdata`=0xDEADBEEF at cycle 3;
  - write response has `rsp_rdata`=0 and `rsp_we`=1.
- STROBE_CYCLES=3: read addr 0x3F → `strobe` high for cycles 2–4, `rsp_valid` at cycle 5, `rd_data` sampled at the edge ending cycle 4.
- Backpressure: hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data stable throughout, `req_ready`=0, a pending `req_valid` is not accepted until one cycle after `rsp_ready`.
- Reset mid-strobe: assert `reset_n`=0 in cycle 2 → `strobe` low within the same cycle (asynchronous), no `rsp_valid` after release.
- Bypass (macro defined): write 0x05←0x1234, read 0x05 → `rsp_valid` at cycle 1 with 0x1234, `enable`/`strobe` stay 0. A read of 0x06 takes the full path.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the toy 64-entry SRAM request-side logic:
//   - SRAM_ADDR_W      : word address width of the array
//   - STROBE_CYCLES_*  : legal range of the strobe length parameter
//   - STROBE_CNT_W     : width of the strobe down-counter
//   - port_state_t     : sequencer FSM states
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_ADDR_W       = 6;
    localparam int STROBE_CYCLES_MIN = 1;
    localparam int STROBE_CYCLES_MAX = 15;
    localparam int STROBE_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } port_state_t;

endpackage

// File: rtl/sram_port_ctl.sv
// -----------------------------------------------------------------------------
// sram_port_ctl
// Request-side sequencer for the 64-entry toy SRAM. Takes one read or write
// request at a time, drives the predecoder (strobe/enable/address) and the
// array write path (wr_enable/wr_data), captures array read data and returns
// a response.
//
// Parameters:
//   DATA_WIDTH    : width of write and read data
//   STROBE_CYCLES : cycles strobe is held high (legal 1..15)
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready          : request handshake
//   req_we, req_addr, req_wdata  : request payload
//   strobe, enable, address      : registered predecoder inputs
//   wr_enable, wr_data           : registered array write controls
//   rd_data                      : array read data
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata, rsp_we            : response payload
//   dbg_state                    : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised, it and its payload stay unchanged until
// that transfer; ready never depends combinationally on valid.
//
// Optional feature: define SRAM_PORT_BYPASS_EN to keep a last-write register.
// A read hitting it skips the array and responds one cycle after accept.
// -----------------------------------------------------------------------------
module sram_port_ctl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [0:SRAM_ADDR_W-1]  req_addr,
    input  logic [0:DATA_WIDTH-1]   req_wdata,
    output logic                    strobe,
    output logic                    enable,
    output logic                    wr_enable,
    output logic [0:SRAM_ADDR_W-1]  address,
    output logic [0:DATA_WIDTH-1]   wr_data,
    input  logic [0:DATA_WIDTH-1]   rd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [0:DATA_WIDTH-1]   rsp_rdata,
    output logic                    rsp_we,
    output port_state_t             dbg_state
);

    // Counter is loaded with S-1 on entering STROBE; STROBE ends when it
    // reads zero, giving exactly S strobe cycles.
    localparam logic [STROBE_CNT_W-1:0] STROBE_LOAD = STROBE_CNT_W'(STROBE_CYCLES - 1);

    port_state_t               state;
    logic [STROBE_CNT_W-1:0]   strobe_cnt;
    logic                      access_done;
    logic                      bypass_hit;
    logic [0:DATA_WIDTH-1]     bypass_rdata;

    assign dbg_state   = state;
    // Last strobe cycle: the edge ending it samples rd_data / commits a write.
    assign access_done = (state == STROBE) && (strobe_cnt == '0);

`ifdef SRAM_PORT_BYPASS_EN
    logic                      byp_valid;
    logic [0:SRAM_ADDR_W-1]    byp_addr;
    logic [0:DATA_WIDTH-1]     byp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_valid <= 1'b0;
            byp_addr  <= '0;
            byp_data  <= '0;
        end else if (access_done && wr_enable) begin
            byp_valid <= 1'b1;
            byp_addr  <= address;
            byp_data  <= wr_data;
        end
    end

    assign bypass_hit   = byp_valid && !req_we && (req_addr == byp_addr);
    assign bypass_rdata = byp_data;
`else
    assign bypass_hit   = 1'b0;
    assign bypass_rdata = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            strobe     <= 1'b0;
            enable     <= 1'b0;
            wr_enable  <= 1'b0;
            address    <= '0;
            wr_data    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_we     <= 1'b0;
            strobe_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        address   <= req_addr;
                        wr_enable <= req_we;
                        wr_data   <= req_wdata;
                        if (bypass_hit) begin
                            // Served from the last-write register; the
                            // predecoder is never touched for this read.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_we    <= 1'b0;
                            rsp_rdata <= bypass_rdata;
                        end else begin
                            state  <= SETUP;
                            enable <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    state      <= STROBE;
                    strobe     <= 1'b1;
                    strobe_cnt <= STROBE_LOAD;
                end

                STROBE: begin
                    if (access_done) begin
                        state     <= RESP;
                        strobe    <= 1'b0;
                        enable    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= wr_enable;
                        rsp_rdata <= wr_enable ? '0 : rd_data;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end

                RESP: begin
                    // Response fields are untouched here, so they hold under
                    // backpressure.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
